// File: rtl/param_cpu_pkg.sv
// Shared opcode/state encodings and instruction field positions for param_cpu.
package param_cpu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b01000,
    OP_OR   = 5'b01001,
    OP_AND  = 5'b01010,
    OP_XOR  = 5'b01011,
    OP_INC  = 5'b01100,
    OP_NOT  = 5'b01101,
    OP_ROR  = 5'b01110,
    OP_ROL  = 5'b01111,
    OP_JNC  = 5'b10000,
    OP_JZ   = 5'b10001,
    OP_JMP  = 5'b10010,
    OP_CALL = 5'b10011,
    OP_MVI  = 5'b10100,
    OP_RET  = 5'b10101,
    OP_IN   = 5'b10110,
    OP_HLT  = 5'b11111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int OP_LSB  = 3;
  localparam int OP_MSB  = 7;
  localparam int SSS_LSB = 0;
  localparam int SSS_MSB = 2;
  localparam int IMM_LSB = 8;
  localparam int IMM_MSB = 15;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int k = 0; k < 8; k++) rev8[k] = v[7-k];
  endfunction

endpackage

// File: rtl/param_cpu_stack.sv
// Return-address LIFO for param_cpu; push and pop are never asserted together.
module param_cpu_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0] sp_q, sp_d;
  // Storage rounded up to a power of two so the pointer indexes it directly.
  logic [W-1:0]    mem [1 << SP_W];

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign top   = mem[sp_q - SP_W'(1)];

  always_comb begin
    sp_d = sp_q;
    if (push && !full)       sp_d = sp_q + SP_W'(1);
    else if (pop && !empty)  sp_d = sp_q - SP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[sp_q] <= din;
  end

endmodule

// File: rtl/param_cpu.sv
// Two-cycle FETCH/EXEC CPU with LED matrix scan output.
// Define PARAM_CPU_CALL_STACK_EN to build the return stack with CALL/RET.
module param_cpu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NREGS       = 8,
  parameter int PC_W        = 11,
  parameter int STACK_DEPTH = 4,
  parameter int SCAN_LSB    = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      btn,
  input  logic [23:0]     counter,
  input  logic [15:0]     dout,
  output logic [PC_W-1:0] pc_out,
  output logic [3:0]      led,
  output logic [7:0]      row,
  output logic [7:0]      col
);
  localparam int RA_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc, target;
  logic              c_q, c_d, z_q, z_d, stk_err_q, stk_err_d;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data, rs, r0, res;
  logic [DATA_W:0]   alu_sum;
  logic [4:0]        op_raw;
  opcode_e           op;
  logic [2:0]        sss;
  logic [7:0]        imm;
  logic [10:0]       target_full;
  logic [15:0]       imm16, btn16, scan16;
  logic [2:0]        scan_idx;
  logic              unused_bits;

  assign op_raw      = dout[OP_MSB:OP_LSB];
  assign op          = opcode_e'(op_raw);
  assign sss         = dout[SSS_MSB:SSS_LSB];
  assign imm         = dout[IMM_MSB:IMM_LSB];
  assign target_full = {imm, sss};
  assign target      = target_full[PC_W-1:0];
  assign imm16       = {8'h00, imm};
  assign btn16       = {8'h00, btn};
  assign rs          = regs_q[RA_W'(sss)];
  assign r0          = regs_q[0];
  assign pc_inc      = pc_q + PC_W'(1);
  assign alu_sum     = {1'b0, r0} + {1'b0, rs};

`ifdef PARAM_CPU_CALL_STACK_EN
  logic            push, pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;

  param_cpu_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top)
  );
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    c_d       = c_q;
    z_d       = z_q;
    stk_err_d = stk_err_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    res       = '0;
`ifdef PARAM_CPU_CALL_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        if (op_raw[4:3] == 2'b00) begin
          wr_en   = 1'b1;
          wr_addr = op_raw[2:0];
          wr_data = rs;
        end else begin
          case (op)
            OP_ADD: begin res = alu_sum[DATA_W-1:0]; c_d = alu_sum[DATA_W]; end
            OP_OR:  begin res = r0 | rs; c_d = 1'b0; end
            OP_AND: begin res = r0 & rs; c_d = 1'b0; end
            OP_XOR: begin res = r0 ^ rs; c_d = 1'b0; end
            OP_INC: begin res = rs + DATA_W'(1); c_d = (res == '0); end
            OP_NOT: res = ~rs;
            OP_ROR: res = {rs[0], rs[DATA_W-1:1]};
            OP_ROL: res = {rs[DATA_W-2:0], rs[DATA_W-1]};
            OP_JNC: begin
              if (!c_q) pc_d = target;
              c_d = 1'b0;
            end
            OP_JZ:  if (z_q) pc_d = target;
            OP_JMP: pc_d = target;
`ifdef PARAM_CPU_CALL_STACK_EN
            OP_CALL: begin
              pc_d = target;
              if (stk_full) stk_err_d = 1'b1;
              else          push      = 1'b1;
            end
            OP_RET: begin
              if (stk_empty) stk_err_d = 1'b1;
              else begin
                pop  = 1'b1;
                pc_d = stk_top;
              end
            end
`endif
            OP_MVI: begin wr_en = 1'b1; wr_addr = sss; wr_data = imm16[DATA_W-1:0]; end
            OP_IN:  begin wr_en = 1'b1; wr_addr = sss; wr_data = btn16[DATA_W-1:0]; end
            OP_HLT: begin pc_d = pc_q; state_d = ST_HALT; end
            default: ;
          endcase
          // Every ALU op (01xxx) writes its result and refreshes Z.
          if (op_raw[4:3] == 2'b01) begin
            wr_en   = 1'b1;
            wr_addr = op_raw[2] ? sss : 3'd0;
            wr_data = res;
            z_d     = (res == '0);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      c_q       <= c_d;
      z_q       <= z_d;
      stk_err_q <= stk_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      regs_q[RA_W'(wr_addr)] <= wr_data;
    end
  end

  // Display scan runs in every state, including HALT.
  assign scan_idx = counter[SCAN_LSB+2:SCAN_LSB];
  assign scan16   = 16'(regs_q[RA_W'(scan_idx)]);
  assign row      = rev8(scan16[7:0]);
  assign col      = ~(8'h80 >> scan_idx);
  assign pc_out   = pc_q;
  assign led      = ~{(state_q == ST_HALT), stk_err_q, z_q, c_q};

  assign unused_bits = ^{counter, scan16, imm16, btn16, target_full};

endmodule
